// File: rtl/i2s_slave_receiver.sv
// I2S bit-clock slave receiver: synchronises the codec ADC pins, deserialises
// right/left slots and presents {L,R} sample pairs over a valid/ready handshake.
module i2s_slave_receiver #(
  parameter int LEADING_BITS = 1,
  parameter int DATA_BITS    = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 codec_aud_bclk_i,
  input  logic                 codec_aud_adclrck_i,
  input  logic                 codec_aud_adcdat_i,
  input  logic                 rx_enable_i,
  output logic [DATA_BITS-1:0] rx_sample_data_L_o,
  output logic [DATA_BITS-1:0] rx_sample_data_R_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_overflow_o,
  output logic                 rx_frame_err_o,
  input  logic                 rx_err_clear_i
);

  localparam int CNT_W = $clog2(LEADING_BITS + DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] FIRST_TICK = CNT_W'(LEADING_BITS);
  localparam logic [CNT_W-1:0] LSB_TICK   = CNT_W'(LEADING_BITS + DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_RECEIVE
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] bclk_sync_reg;
  logic [SYNC_STAGES-1:0] lrck_sync_reg;
  logic [SYNC_STAGES-1:0] dat_sync_reg;
  logic                   bclk_d_reg;
  logic                   lrck_prev_reg;
  logic [CNT_W-1:0]       cnt_reg;

  logic [DATA_BITS-1:0]   shift_reg;
  logic [DATA_BITS-1:0]   hold_r_reg;
  logic                   r_captured_reg;
  logic                   word_done_reg;
  logic                   word_lrck_reg;
  logic                   pair_done_reg;
  logic [DATA_BITS-1:0]   pair_l_reg;
  logic [DATA_BITS-1:0]   pair_r_reg;

  logic                   bclk_s;
  logic                   lrck_s;
  logic                   dat_s;
  logic                   bclk_rise;
  logic                   lrck_edge;
  logic [CNT_W-1:0]       tick_now;
  logic                   align_hit;
  logic                   slot_active;
  logic                   short_slot;
  logic                   capture;
  logic                   last_bit;
  logic                   disable_rx;
  logic [DATA_BITS-1:0]   shift_base;
  logic                   out_load;
  logic                   out_drop;

  // Metastability chains for the three asynchronous codec pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_reg <= '0;
      lrck_sync_reg <= '0;
      dat_sync_reg  <= '0;
      bclk_d_reg    <= 1'b0;
    end else begin
      bclk_sync_reg <= {bclk_sync_reg[SYNC_STAGES-2:0], codec_aud_bclk_i};
      lrck_sync_reg <= {lrck_sync_reg[SYNC_STAGES-2:0], codec_aud_adclrck_i};
      dat_sync_reg  <= {dat_sync_reg[SYNC_STAGES-2:0], codec_aud_adcdat_i};
      bclk_d_reg    <= bclk_s;
    end
  end

  assign bclk_s    = bclk_sync_reg[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_reg[SYNC_STAGES-1];
  assign dat_s     = dat_sync_reg[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_d_reg;
  assign lrck_edge = lrck_s ^ lrck_prev_reg;

  always_comb begin
    tick_now = cnt_reg;
    if (lrck_edge) begin
      tick_now = '0;
    end else if (cnt_reg != CNT_MAX) begin
      tick_now = cnt_reg + CNT_W'(1);
    end
  end

  // The falling LRCK boundary that ends alignment is already tick 0 of a live right slot
  assign align_hit   = (state_reg == ST_ALIGN) && rx_enable_i && bclk_rise && lrck_edge && !lrck_s;
  assign slot_active = bclk_rise && rx_enable_i && ((state_reg == ST_RECEIVE) || align_hit);
  assign short_slot  = bclk_rise && rx_enable_i && (state_reg == ST_RECEIVE) && lrck_edge &&
                       (cnt_reg < LSB_TICK);
  assign capture     = slot_active && (tick_now >= FIRST_TICK) && (tick_now <= LSB_TICK);
  assign last_bit    = capture && (tick_now == LSB_TICK);
  assign disable_rx  = (state_reg == ST_RECEIVE) && !rx_enable_i;
  assign shift_base  = short_slot ? '0 : shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rx_enable_i) state_next = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (!rx_enable_i) begin
          state_next = ST_IDLE;
        end else if (align_hit) begin
          state_next = ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        if (!rx_enable_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Slot tracking runs in every state so LRCK history is current when alignment starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrck_prev_reg <= 1'b0;
      cnt_reg       <= '0;
    end else if (bclk_rise) begin
      lrck_prev_reg <= lrck_s;
      cnt_reg       <= tick_now;
    end
  end

  // Three-step pipeline: shift in the LSB, then pair the words, then present them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg      <= '0;
      hold_r_reg     <= '0;
      r_captured_reg <= 1'b0;
      word_done_reg  <= 1'b0;
      word_lrck_reg  <= 1'b0;
      pair_done_reg  <= 1'b0;
      pair_l_reg     <= '0;
      pair_r_reg     <= '0;
    end else if (disable_rx) begin
      shift_reg      <= '0;
      r_captured_reg <= 1'b0;
      word_done_reg  <= 1'b0;
      pair_done_reg  <= 1'b0;
    end else begin
      if (capture) begin
        shift_reg <= {shift_base[DATA_BITS-2:0], dat_s};
      end else if (short_slot) begin
        shift_reg <= '0;
      end
      word_done_reg <= last_bit;
      word_lrck_reg <= lrck_s;

      pair_done_reg <= word_done_reg && word_lrck_reg && r_captured_reg;
      if (word_done_reg && word_lrck_reg && r_captured_reg) begin
        pair_l_reg <= shift_reg;
        pair_r_reg <= hold_r_reg;
      end
      if (word_done_reg && !word_lrck_reg) begin
        hold_r_reg <= shift_reg;
      end

      if (short_slot) begin
        r_captured_reg <= 1'b0;
      end else if (word_done_reg) begin
        r_captured_reg <= !word_lrck_reg;
      end
    end
  end

  assign out_load = pair_done_reg && (!rx_valid_o || rx_ready_i);
  assign out_drop = pair_done_reg && rx_valid_o && !rx_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sample_data_L_o <= '0;
      rx_sample_data_R_o <= '0;
      rx_valid_o         <= 1'b0;
      rx_overflow_o      <= 1'b0;
      rx_frame_err_o     <= 1'b0;
    end else begin
      if (out_load) begin
        rx_sample_data_L_o <= pair_l_reg;
        rx_sample_data_R_o <= pair_r_reg;
        rx_valid_o         <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      // A set event in the clearing cycle keeps the flag up
      rx_overflow_o  <= out_drop | (rx_overflow_o & ~rx_err_clear_i);
      rx_frame_err_o <= short_slot | (rx_frame_err_o & ~rx_err_clear_i);
    end
  end

endmodule

// File: tb/tb_i2s_slave_receiver.sv
// Directed bench for i2s_slave_receiver: a table of I2S frames with expected
// pairs/flags, plus hand-written sequences for alignment, overflow and reset.
module tb_i2s_slave_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bclk = 1'b0;
  logic        lrck = 1'b0;
  logic        dat = 1'b0;
  logic        en = 1'b0;
  logic        ready = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] out_l;
  logic [15:0] out_r;
  logic        valid;
  logic        ovf;
  logic        ferr;

  int checks = 0;
  int failures = 0;
  logic [15:0] got_l[$];
  logic [15:0] got_r[$];
  event lsb_ev;

  typedef struct {
    logic [15:0] r;
    logic [15:0] l;
    int          rt;
    bit          mark;
    bit          exp_pair;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  i2s_slave_receiver #(
    .LEADING_BITS(1),
    .DATA_BITS(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .codec_aud_bclk_i    (bclk),
    .codec_aud_adclrck_i (lrck),
    .codec_aud_adcdat_i  (dat),
    .rx_enable_i         (en),
    .rx_sample_data_L_o  (out_l),
    .rx_sample_data_R_o  (out_r),
    .rx_valid_o          (valid),
    .rx_ready_i          (ready),
    .rx_overflow_o       (ovf),
    .rx_frame_err_o      (ferr),
    .rx_err_clear_i      (clr)
  );

  // Pairs transferred on the coming edge; ready only changes just after a posedge
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      got_l.push_back(out_l);
      got_r.push_back(out_r);
      $display("pair accepted L=%h R=%h at %0t", out_l, out_r, $time);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic realign;
    @(negedge clk);
    #2;
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input int n, input bit mark);
    for (int t = 0; t < n; t++) begin
      bclk = 1'b0;
      lrck = lr;
      dat  = (t >= 1 && t <= 16) ? w[16-t] : 1'b0;
      #40;
      bclk = 1'b1;
      if (mark && t == 16) -> lsb_ev;
      #40;
    end
  endtask

  task automatic send_frame(input logic [15:0] r, input logic [15:0] l, input int rt, input bit mark);
    send_slot(1'b0, r, rt, 1'b0);
    send_slot(1'b1, l, 32, mark);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
    realign();
  endtask

  task automatic pulse_clear;
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic lat_watch;
    @(lsb_ev);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 chk("lat_early", valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_valid", valid, 1'b1);
    chk("lat_L", out_l, 16'hABCD);
    chk("lat_R", out_r, 16'h1234);
  endtask

  task automatic simul_watch;
    @(lsb_ev);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    chk("simul_valid", valid, 1'b1);
    chk("simul_ovf", ovf, 1'b0);
    chk("simul_L", out_l, 16'h8888);
    chk("simul_R", out_r, 16'h7777);
  endtask

  initial begin
    #2ms;
    failures++;
    $display("FAIL timeout: simulation did not finish at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'h1234, 16'hABCD, 32, 1'b1, 1'b1, 16'hABCD, 16'h1234, 1'b0};
    vecs[1] = '{16'h0F0F, 16'h3333, 10, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[2] = '{16'h5555, 16'hAAAA, 32, 1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b1};
    vecs[3] = '{16'h0000, 16'hFFFF, 32, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1};
    vecs[4] = '{16'h8001, 16'h7FFE, 32, 1'b0, 1'b1, 16'h7FFE, 16'h8001, 1'b1};

    // Reset state
    en = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_L", out_l, 16'h0000);
    chk("rst_R", out_r, 16'h0000);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_err", ferr, 1'b0);
    realign();
    rst_n = 1'b1;
    repeat (3) realign();
    chk("post_rst_valid", valid, 1'b0);

    // A few left ticks so the first right slot starts with a falling LRCK edge
    send_slot(1'b1, 16'h0000, 8, 1'b0);
    fork
      lat_watch();
    join_none
    for (int i = 0; i < 5; i++) begin
      int n0;
      n0 = got_l.size();
      send_frame(vecs[i].r, vecs[i].l, vecs[i].rt, vecs[i].mark);
      $display("frame %0d sent R=%h L=%h rticks=%0d", i, vecs[i].r, vecs[i].l, vecs[i].rt);
      chk($sformatf("v%0d_count", i), got_l.size() - n0, {31'd0, vecs[i].exp_pair});
      if (vecs[i].exp_pair && got_l.size() > n0) begin
        chk($sformatf("v%0d_L", i), got_l[n0], vecs[i].exp_l);
        chk($sformatf("v%0d_R", i), got_r[n0], vecs[i].exp_r);
      end
      chk($sformatf("v%0d_err", i), ferr, vecs[i].exp_err);
      chk($sformatf("v%0d_ovf", i), ovf, 1'b0);
    end
    pulse_clear();
    chk("err_cleared", ferr, 1'b0);
    realign();

    // Enable asserted in the middle of a left slot
    rst_n = 1'b0;
    en = 1'b0;
    realign();
    rst_n = 1'b1;
    got_l.delete();
    got_r.delete();
    send_slot(1'b1, 16'hC3A5, 8, 1'b0);
    en = 1'b1;
    send_slot(1'b1, 16'h5A5A, 24, 1'b0);
    send_frame(16'h0001, 16'h8000, 32, 1'b0);
    send_frame(16'h7FFF, 16'hFFFF, 32, 1'b0);
    chk("mid_count", got_l.size(), 32'd2);
    if (got_l.size() == 2) begin
      chk("mid_p0_L", got_l[0], 16'h8000);
      chk("mid_p0_R", got_r[0], 16'h0001);
      chk("mid_p1_L", got_l[1], 16'hFFFF);
      chk("mid_p1_R", got_r[1], 16'h7FFF);
    end
    chk("mid_err", ferr, 1'b0);

    // Backpressure across three frames
    set_ready(1'b0);
    got_l.delete();
    got_r.delete();
    send_frame(16'h1111, 16'h2222, 32, 1'b0);
    chk("bp1_valid", valid, 1'b1);
    chk("bp1_L", out_l, 16'h2222);
    chk("bp1_R", out_r, 16'h1111);
    chk("bp1_ovf", ovf, 1'b0);
    send_frame(16'h3333, 16'h4444, 32, 1'b0);
    chk("bp2_ovf", ovf, 1'b1);
    chk("bp2_L", out_l, 16'h2222);
    chk("bp2_R", out_r, 16'h1111);
    send_frame(16'h5555, 16'h6666, 32, 1'b0);
    chk("bp3_L", out_l, 16'h2222);
    chk("bp3_ovf", ovf, 1'b1);
    pulse_clear();
    chk("ovf_cleared", ovf, 1'b0);
    chk("bp_valid_kept", valid, 1'b1);
    chk("bp_none_taken", got_l.size(), 32'd0);
    realign();

    // New pair lands on the same edge that accepts the old one
    fork
      simul_watch();
    join_none
    send_frame(16'h7777, 16'h8888, 32, 1'b1);
    chk("simul_count", got_l.size(), 32'd1);
    if (got_l.size() == 1) begin
      chk("simul_old_L", got_l[0], 16'h2222);
      chk("simul_old_R", got_r[0], 16'h1111);
    end
    set_ready(1'b1);
    realign();
    chk("drain_count", got_l.size(), 32'd2);
    if (got_l.size() == 2) chk("drain_L", got_l[1], 16'h8888);
    chk("drain_valid", valid, 1'b0);

    // Asynchronous reset in the middle of a right slot
    set_ready(1'b0);
    send_frame(16'h2222, 16'h1111, 32, 1'b0);
    send_frame(16'h4444, 16'h3333, 32, 1'b0);
    chk("pre_rst_ovf", ovf, 1'b1);
    send_slot(1'b0, 16'hFFFF, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 1'b0);
    chk("arst_L", out_l, 16'h0000);
    chk("arst_R", out_r, 16'h0000);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_err", ferr, 1'b0);
    realign();
    rst_n = 1'b1;
    got_l.delete();
    got_r.delete();
    set_ready(1'b1);
    send_slot(1'b0, 16'hFFFF, 27, 1'b0);
    send_slot(1'b1, 16'hFFFF, 32, 1'b0);
    chk("arst_align_none", got_l.size(), 32'd0);
    send_frame(16'h2468, 16'h1357, 32, 1'b0);
    chk("arst_count", got_l.size(), 32'd1);
    if (got_l.size() == 1) begin
      chk("arst_L_pair", got_l[0], 16'h1357);
      chk("arst_R_pair", got_r[0], 16'h2468);
    end
    chk("arst_err_end", ferr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_slave_receiver.md
Name: i2s_slave_receiver

Overview:
- Receives stereo PCM from the audio codec ADC over I2S. The codec supplies BCLK and ADCLRCK; the block is a bit-clock slave.
- Mirror of the DAC-side I2S master. Frame polarity and bit placement are identical: LRCK low = right slot, LRCK high = left slot, MSB first, one leading bit after each LRCK edge.
- Deserialises each slot and delivers {L,R} sample pairs to the buffer logic over a valid/ready handshake.
- Flags overflow and malformed slots.

Parameters:
- LEADING_BITS, 1: BCLK ticks after an LRCK edge before the MSB arrives.
- DATA_BITS, 16: sample width.
- SYNC_STAGES, 2: flip-flop synchroniser depth on the three codec inputs (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x BCLK.
- rst_n  in  1  asynchronous active-low reset.
- codec_aud_bclk_i  in  1  codec bit clock; asynchronous to clk.
- codec_aud_adclrck_i  in  1  codec ADC word clock; asynchronous to clk.
- codec_aud_adcdat_i  in  1  codec ADC serial data; asynchronous to clk.
- rx_enable_i  in  1  receiver enable.
- rx_sample_data_L_o  out  DATA_BITS  left sample of the presented pair.
- rx_sample_data_R_o  out  DATA_BITS  right sample of the presented pair.
- rx_valid_o  out  1  pair available.
- rx_ready_i  in  1  consumer accepts the pair.
- rx_overflow_o  out  1  sticky: a completed pair was dropped.
- rx_frame_err_o  out  1  sticky: a slot ended before DATA_BITS bits were received.
- rx_err_clear_i  in  1  clears both sticky flags.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE.
  - All outputs, shift register, bit counter and R_captured flag = 0.
  - Synchroniser flops = 0.
- Input synchronisation and edge detection:
  - All three pins pass through SYNC_STAGES flops.
  - bclk_rise = synced BCLK 1 now, 0 one cycle earlier.
  - All slot logic advances only on bclk_rise, using synced LRCK/DAT of the same cycle.
- Slot tracking on each bclk_rise:
  - If synced LRCK differs from the stored lrck_prev, a slot boundary is detected: tick counter = 0 and this edge is tick 0. Otherwise the counter increments and saturates at 2^ceil(log2(LEADING_BITS+DATA_BITS+1))-1.
  - Ticks LEADING_BITS .. LEADING_BITS+DATA_BITS-1 shift DAT into the shift register, MSB first.
  - Later ticks are ignored (trailing bits).
- Word completion (at the tick where the LSB is captured):
  - Slot LRCK=0: latch the word into the R holding register and set R_captured.
  - Slot LRCK=1: if R_captured, form pair {L=word, R=holding} and clear R_captured. If not R_captured, discard the word.
- FSM:
  - IDLE: wait for rx_enable_i=1, then go to ALIGN.
  - ALIGN: ignore data until a falling LRCK boundary (start of a right slot), then go to RECEIVE. That boundary tick counts as tick 0.
  - RECEIVE: normal operation. rx_enable_i=0 goes to IDLE in the next cycle, clears R_captured and discards the partial word. A pending rx_valid_o/pair is retained.
- Short slot:
  - Trigger: a slot boundary in RECEIVE before the current slot reached its LSB tick.
  - Actions: set rx_frame_err_o, discard the partial word, clear R_captured.
  - The new slot is processed normally.
- Output handshake:
  - A pair is transferred on a clk edge with rx_valid_o & rx_ready_i.
  - rx_valid_o and the data are stable while rx_valid_o=1 and rx_ready_i=0.
  - A new pair completing when rx_valid_o=0 loads the outputs and sets rx_valid_o in the following cycle.
  - A new pair completing when rx_valid_o=1 and rx_ready_i=1 in the same cycle is accepted: the old pair leaves and the new pair loads, so rx_valid_o stays 1.
  - A new pair completing when rx_valid_o=1 and rx_ready_i=0 is dropped: rx_overflow_o is set and the old pair is kept.
- Latency: rx_valid_o rises exactly SYNC_STAGES+2 clk edges after the clk edge that first samples the BCLK pin high on the left-slot LSB tick.
- Sticky flags:
  - rx_err_clear_i=1 clears both flags next cycle.
  - A set event in the same cycle as a clear wins, so the flag stays 1.
- rx_ready_i is ignored while rx_valid_o=0.

Test Plan:
- Reset with rx_enable_i=1, feed one I2S frame R=0x1234, L=0xABCD (BCLK=clk/8, 32 ticks/slot) -> pair L=0xABCD, R=0x1234, rx_valid_o at the specified latency; rx_frame_err_o and rx_overflow_o stay 0.
- Enable asserted mid left slot, then frames (R=0x0001, L=0x8000) and (R=0x7FFF, L=0xFFFF) -> partial slot ignored in ALIGN; exactly two pairs delivered, in order, with exact values.
- rx_ready_i held 0 across three frames -> first pair held stable; rx_overflow_o=1 after the second frame; rx_err_clear_i pulse -> flag returns to 0.
- Right slot shortened to 10 ticks, then a good frame R=0x5555, L=0xAAAA -> rx_frame_err_o=1; the corrupt pair is never emitted; the next good pair is delivered correctly.
- Pair completes on the same cycle that rx_ready_i accepts the previous pair -> no overflow, rx_valid_o stays 1, data updates to the new pair.
- rst_n asserted asynchronously mid slot -> all outputs 0 immediately without a clk edge; after release, ALIGN is required before the next delivered pair.
